// File: rtl/freelist_bitmap_pkg.sv
// Shared free-list definitions: default configuration, physical tag type,
// free-count width and the reset availability image.
package freelist_bitmap_pkg;

    localparam int DEF_N         = 3;
    localparam int DEF_PHYS_REGS = 64;
    localparam int DEF_ARCH_REGS = 32;

    localparam int PHYS_TAG_W    = $clog2(DEF_PHYS_REGS);
    localparam int FREE_CNT_W    = $clog2(DEF_PHYS_REGS + 1);

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

    // Architectural mappings occupy PR 0..ARCH_REGS-1 out of reset; the retire
    // checkpoint uses the same image as its reset value.
    localparam logic [DEF_PHYS_REGS-1:0] FREELIST_INIT_MASK =
        {{(DEF_PHYS_REGS - DEF_ARCH_REGS){1'b1}}, {DEF_ARCH_REGS{1'b0}}};

endpackage

// File: rtl/psel_multi.sv
// N-way cascaded priority selector: each requesting lane, in lane order, takes
// the lowest set bit of the request map not already taken by an earlier lane.
module psel_multi #(
    parameter  int N     = 3,
    parameter  int W     = 64,
    localparam int TAG_W = $clog2(W)
) (
    input  logic [W-1:0]            req_map,
    input  logic [N-1:0]            lane_req,
    output logic [N-1:0][W-1:0]     gnt_onehot,
    output logic [N-1:0]            gnt_valid,
    output logic [N-1:0][TAG_W-1:0] gnt_tag
);

    logic [W-1:0] remaining;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_onehot = '0;
        gnt_valid  = '0;
        gnt_tag    = '0;
        remaining  = req_map;
        for (int i = 0; i < N; i++) begin
            if (lane_req[i]) begin
                // Two's-complement trick isolates the lowest set bit.
                gnt_onehot[i] = remaining & (~remaining + W'(1));
                gnt_valid[i]  = |gnt_onehot[i];
                for (int j = 0; j < W; j++) begin
                    if (gnt_onehot[i][j]) gnt_tag[i] = TAG_W'(j);
                end
                remaining = remaining & ~gnt_onehot[i];
            end
        end
    end

endmodule

// File: rtl/freelist_bitmap.sv
// Physical-register free list: bitmap of free PRs, up to N grants per cycle,
// registered free count. Define FREELIST_CHECK_EN for simulation-only checks.
module freelist_bitmap
    import freelist_bitmap_pkg::*;
#(
    parameter  int N         = DEF_N,
    parameter  int PHYS_REGS = DEF_PHYS_REGS,
    parameter  int ARCH_REGS = DEF_ARCH_REGS,
    localparam int TAG_W     = $clog2(PHYS_REGS),
    localparam int CNT_W     = $clog2(PHYS_REGS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N-1:0]            alloc_req,
    output logic [N-1:0]            alloc_valid,
    output logic [N-1:0][TAG_W-1:0] alloc_tags,
    input  logic [PHYS_REGS-1:0]    free_mask,
    input  logic                    mispredict,
    input  logic [PHYS_REGS-1:0]    restore_mask,
    output logic [CNT_W-1:0]        free_count
);

    localparam logic [PHYS_REGS-1:0] INIT_MASK =
        {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

    logic [PHYS_REGS-1:0]            avail;
    logic [PHYS_REGS-1:0]            avail_next;
    logic [PHYS_REGS-1:0]            sel_map;
    logic [PHYS_REGS-1:0]            granted;
    logic [N-1:0][PHYS_REGS-1:0]     gnt_onehot;
    logic [N-1:0]                    gnt_valid;
    logic [N-1:0][TAG_W-1:0]         gnt_tag;
    logic [CNT_W-1:0]                count_next;
    logic                            grant_en;

    // PR0 is hardwired busy for selection purposes.
    assign sel_map  = {avail[PHYS_REGS-1:1], 1'b0};
    assign grant_en = reset & ~mispredict;

    psel_multi #(
        .N (N),
        .W (PHYS_REGS)
    ) u_psel (
        .req_map    (sel_map),
        .lane_req   (alloc_req),
        .gnt_onehot (gnt_onehot),
        .gnt_valid  (gnt_valid),
        .gnt_tag    (gnt_tag)
    );

    always_comb begin
        alloc_valid = '0;
        alloc_tags  = '0;
        granted     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_en && gnt_valid[i]) begin
                alloc_valid[i] = 1'b1;
                alloc_tags[i]  = gnt_tag[i];
                granted        = granted | gnt_onehot[i];
            end
        end
    end

    // Restore image already folds in this cycle's retire frees.
    always_comb begin
        avail_next = mispredict ? restore_mask : ((avail & ~granted) | free_mask);
        count_next = '0;
        for (int j = 0; j < PHYS_REGS; j++) begin
            count_next = count_next + CNT_W'(avail_next[j]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            avail      <= INIT_MASK;
            free_count <= CNT_W'(PHYS_REGS - ARCH_REGS);
        end else begin
            avail      <= avail_next;
            free_count <= count_next;
        end
    end

`ifdef FREELIST_CHECK_EN
    always @(posedge clock) begin
        if (reset) begin
            if (!mispredict && |(free_mask & avail))
                $error("freelist: double free, mask %h", free_mask & avail);
            if (!mispredict && free_mask[0])
                $error("freelist: free of PR0");
            if (mispredict && restore_mask[0])
                $error("freelist: restore image marks PR0 free");
            for (int i = 0; i < N; i++) begin
                for (int j = i + 1; j < N; j++) begin
                    if (alloc_valid[i] && alloc_valid[j] && alloc_tags[i] == alloc_tags[j])
                        $error("freelist: duplicate grant of tag %0d", alloc_tags[i]);
                end
            end
            $display("freelist: t=%0t grant_v=%b tags=%h free=%h", $time, alloc_valid, alloc_tags, free_mask);
        end
    end
`else
    // Checker compiled out.
`endif

endmodule

// File: doc/freelist_bitmap.md
Name: freelist_bitmap

Overview:
- Physical-register free list at the far end of the retire-to-freelist interface.
- Accepts the retire-side release bitmap (`free_mask`) and the mispredict restore bitmap (`freelist_restore_mask`).
- Hands up to `N` free physical tags per cycle to dispatch/rename.
- Holds the speculative availability bitmap and a registered free count that dispatch uses for stall decisions.

Parameters:
- N, `N, superscalar width (allocation lanes).
- PHYS_REGS, `PHYS_REG_SZ_R10K, number of physical registers.
- ARCH_REGS, `ARCH_REG_SZ, architectural registers; PR 0..ARCH_REGS-1 busy at reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- alloc_req  in  N  per-lane allocation request from dispatch, lane 0 oldest.
- alloc_valid  out  N  per-lane grant, same cycle as request.
- alloc_tags  out  N x PHYS_TAG  granted tag per lane; '0 when not granted.
- free_mask  in  PHYS_REGS  PRs released by retire this cycle.
- mispredict  in  1  retire-head mispredict.
- restore_mask  in  PHYS_REGS  full availability image to load on mispredict.
- free_count  out  $clog2(PHYS_REGS+1)  registered popcount of the availability bitmap.

Behaviour:
- State: `avail[PHYS_REGS]` (1 = free) and `free_count`.
- Async reset (reset==0):
  - avail = {ones for PHYS_REGS-ARCH_REGS bits, zeros for ARCH_REGS bits}.
  - free_count = PHYS_REGS-ARCH_REGS.
  - alloc_valid = 0 and alloc_tags = 0 while reset is held.
- Grant, combinational, zero latency:
  - Computed from the current registered `avail` with bit 0 masked off; PR0 is never granted.
  - Lanes are scanned 0..N-1. Each requesting lane takes the lowest-index free PR not already taken by a lower requesting lane.
  - Non-requesting lanes get valid=0, tag=0 and consume nothing.
- Exhaustion:
  - If fewer free PRs exist than requests, the lowest-indexed requesting lanes are granted; the remainder get valid=0.
  - Grants are never out of order. Dispatch must stall on any requesting lane with valid=0.
- Frees:
  - A `free_mask` bit set this cycle becomes allocatable next cycle, not the same cycle (no bypass).
- Next state, normal cycle: avail_next = (avail & ~granted_onehots) | free_mask.
- Next state, mispredict==1:
  - avail_next = restore_mask, taken verbatim; it already includes this cycle's retire frees.
  - All alloc_valid are forced 0 that cycle.
  - free_mask is ignored.
- Grant and free of the same PR in the same cycle cannot occur, because a granted PR is free and a freed PR is busy. The design does not arbitrate between them.
- free_count_next = popcount(avail_next), registered. Dispatch sees the count with one cycle of lag relative to frees.
- Reset deasserting mid-stream: the first cycle after release behaves as a normal cycle on the reset image.

Optional Feature:
- FREELIST_CHECK_EN defined, adds simulation-only checks:
  - $error on freeing a PR that is already free (double free).
  - $error on a free_mask bit 0 set.
  - $error on duplicate tags among valid grants.
  - $error on restore_mask with bit 0 set.
  - Per-cycle $display of grants and frees.
- FREELIST_CHECK_EN undefined: no checks or prints; RTL is identical otherwise.

Decomposition:
- Shared package / sys_defs.svh:
  - PHYS_TAG typedef.
  - FREELIST_INIT_MASK constant, shared with the retire checkpoint reset value.
  - The free_count width localparam.
- One sub-module, `psel_multi`: a parameterized N-way cascaded priority selector. It takes a request bitmap and lane requests, and returns N one-hot grant vectors plus encoded tags. It is reused by RS issue select.

Test Plan:
Configuration for all scenarios: N=3, PHYS_REGS=64, ARCH_REGS=32.
- Reset release, req=3'b111 -> tags 32,33,34, valid 3'b111; next cycle free_count=29.
- From reset, req=3'b101 -> lane0 tag 32, lane2 tag 33, lane1 valid=0/tag 0; next cycle free_count=30.
- Allocate PR5 via restore, then free_mask bit 5 with req=3'b001 the same cycle -> grant is not 5; the following cycle req=3'b001 gets tag 5.
- With 2 free PRs (40, 41), req=3'b111 -> lanes 0/1 get 40/41, lane2 valid=0; next cycle free_count=0 and any request gets valid=0.
- mispredict=1, restore_mask=FREELIST_INIT_MASK, req=3'b111 -> all valid=0; next cycle free_count=32 and req=3'b001 gets tag 32.
- reset pulled low asynchronously mid-cycle after allocations -> free_count=32 and alloc_valid=0 immediately, without a clock edge. With FREELIST_CHECK_EN, a double free of PR40 raises $error.
